fused_bank_loader: RTL

Parametrised sequencer that copies the IFM tile and the layer-1/layer-2 weight regions from the global 128-bit BRAM into the fused engine's local banks. Replaces the fixed 21-enable loader with configurable bank counts, interleaved weight distribution, read-latency compensation, flow-control hold and bank-overflow detection. Sits between the global BRAM read port and the write ports of the IFM bank and all weight banks.

---
 rtl/fused_loader_pkg.sv | 41 ++++
 rtl/fused_bank_loader_rd_pipe.sv | 62 ++++++
 rtl/fused_bank_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fused_loader_pkg.sv
// Shared types and helpers for the fused bank loader: FSM states, load regions,
// index-width helper and write-enable bit positions.
package fused_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_IFM,
      ST_LOAD_W1,
      ST_LOAD_W2,
      ST_DRAIN,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      RG_IFM,
      RG_W1,
      RG_W2
   } region_e;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // we_fused layout: L1 banks from bit 0, then L2 banks, IFM bank on top
   function automatic int we_l2_base(input int n_l1);
      return n_l1;
   endfunction

   function automatic int we_ifm_idx(input int n_l1, input int n_l2);
      return n_l1 + n_l2;
   endfunction

   // First non-empty region among the remaining ones; DRAIN when all are empty
   function automatic state_e first_load(input logic nz_ifm, input logic nz_w1, input logic nz_w2);
      if (nz_ifm)     return ST_LOAD_IFM;
      else if (nz_w1) return ST_LOAD_W1;
      else if (nz_w2) return ST_LOAD_W2;
      else            return ST_DRAIN;
   endfunction

endpackage

// File: rtl/fused_bank_loader_rd_pipe.sv
// Destination shift register that tracks each global read until its data returns
// RD_LATENCY cycles later.
module fused_rd_pipe #(
   parameter int LAT = 1,
   parameter int IW  = 5,
   parameter int AW  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          in_ovf,
   input  logic [IW-1:0] in_bank,
   input  logic [AW-1:0] in_addr,
   output logic          out_valid,
   output logic          out_ovf,
   output logic [IW-1:0] out_bank,
   output logic [AW-1:0] out_addr,
   output logic          pend
);

   logic [LAT-1:0] vld;
   logic [LAT-1:0] ovf;
   logic [IW-1:0]  bank [LAT];
   logic [AW-1:0]  addr [LAT];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld <= '0;
         ovf <= '0;
         for (int i = 0; i < LAT; i++) begin
            bank[i] <= '0;
            addr[i] <= '0;
         end
      end else begin
         vld[0]  <= in_valid;
         ovf[0]  <= in_ovf;
         bank[0] <= in_bank;
         addr[0] <= in_addr;
         for (int i = 1; i < LAT; i++) begin
            vld[i]  <= vld[i-1];
            ovf[i]  <= ovf[i-1];
            bank[i] <= bank[i-1];
            addr[i] <= addr[i-1];
         end
      end
   end

   assign out_valid = vld[LAT-1];
   assign out_ovf   = ovf[LAT-1];
   assign out_bank  = bank[LAT-1];
   assign out_addr  = addr[LAT-1];

   // Reads that will still produce a write after the current cycle
   generate
      if (LAT > 1) begin : g_pend
         assign pend = |vld[LAT-2:0];
      end else begin : g_nopend
         assign pend = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/fused_bank_loader.sv
// Copies the IFM tile and layer-1/layer-2 weights from global BRAM into the fused
// engine's local banks. Optional XOR checksum output under FUSED_LOADER_CHECKSUM_EN.
//
// state       | meaning
// ST_IDLE     | waiting for start; latches region bases/sizes
// ST_LOAD_IFM | issuing IFM reads, one per non-held cycle
// ST_LOAD_W1  | issuing layer-1 weight reads, interleaved over L1 banks
// ST_LOAD_W2  | issuing layer-2 weight reads, interleaved over L2 banks
// ST_DRAIN    | waiting for in-flight reads to be written
// ST_DONE     | one-cycle done pulse
module fused_bank_loader
   import fused_loader_pkg::*;
#(
   parameter int DATA_W       = 128,
   parameter int ADDR_W       = 32,
   parameter int NUM_L1_BANKS = 16,
   parameter int NUM_L2_BANKS = 4,
   parameter int BANK_DEPTH   = 36,
   parameter int BYTE_SHIFT   = 4,
   parameter int RD_LATENCY   = 1
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic                                     hold,
   input  logic [ADDR_W-1:0]                        base_addr_IFM,
   input  logic [ADDR_W-1:0]                        size_IFM,
   input  logic [ADDR_W-1:0]                        base_addr_Weight_layer_1,
   input  logic [ADDR_W-1:0]                        size_Weight_layer_1,
   input  logic [ADDR_W-1:0]                        base_addr_Weight_layer_2,
   input  logic [ADDR_W-1:0]                        size_Weight_layer_2,
   output logic [ADDR_W-1:0]                        rd_addr_global,
   output logic                                     rd_en_global,
   input  logic [DATA_W-1:0]                        data_in_global,
   output logic [ADDR_W-1:0]                        wr_addr_fused,
   output logic [DATA_W-1:0]                        wr_data_fused,
   output logic [NUM_L1_BANKS+NUM_L2_BANKS:0]       we_fused,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     overflow
`ifdef FUSED_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]                        checksum
`endif
);

   localparam int NB      = NUM_L1_BANKS + NUM_L2_BANKS + 1;
   localparam int IW      = idx_w(NB);
   localparam int BKW     = idx_w((NUM_L1_BANKS > NUM_L2_BANKS) ? NUM_L1_BANKS : NUM_L2_BANKS);
   localparam int L2_BASE = we_l2_base(NUM_L1_BANKS);
   localparam int IFM_IDX = we_ifm_idx(NUM_L1_BANKS, NUM_L2_BANKS);

   state_e            state;
   logic [ADDR_W-1:0] base_ifm, base_w1, base_w2;
   logic [ADDR_W-1:0] cnt_ifm, cnt_w1, cnt_w2;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] laddr;
   logic [BKW-1:0]    bank_ctr;

   region_e           rgn;
   logic              loading;
   logic              issue;
   logic              last_issue;
   logic              bank_wrap;
   logic [ADDR_W-1:0] cur_base, cur_cnt;
   logic [IW-1:0]     dst_bank;
   logic [ADDR_W-1:0] dst_addr;
   logic              dst_ovf;

   always_comb begin
      loading  = 1'b1;
      rgn      = RG_IFM;
      cur_base = base_ifm;
      cur_cnt  = cnt_ifm;
      case (state)
         ST_LOAD_IFM: ;
         ST_LOAD_W1: begin
            rgn      = RG_W1;
            cur_base = base_w1;
            cur_cnt  = cnt_w1;
         end
         ST_LOAD_W2: begin
            rgn      = RG_W2;
            cur_base = base_w2;
            cur_cnt  = cnt_w2;
         end
         default: loading = 1'b0;
      endcase

      dst_bank  = IW'(IFM_IDX);
      dst_addr  = idx;
      bank_wrap = 1'b0;
      case (rgn)
         RG_W1: begin
            dst_bank  = IW'(bank_ctr);
            dst_addr  = laddr;
            bank_wrap = (bank_ctr == BKW'(NUM_L1_BANKS - 1));
         end
         RG_W2: begin
            dst_bank  = IW'(L2_BASE) + IW'(bank_ctr);
            dst_addr  = laddr;
            bank_wrap = (bank_ctr == BKW'(NUM_L2_BANKS - 1));
         end
         default: ;
      endcase
   end

   assign issue          = loading & ~hold;
   assign last_issue     = (idx == cur_cnt - ADDR_W'(1));
   assign dst_ovf        = (dst_addr >= ADDR_W'(BANK_DEPTH));
   assign rd_en_global   = issue;
   assign rd_addr_global = issue ? (cur_base + (idx << BYTE_SHIFT)) : '0;

   logic              p_valid, p_ovf, p_pend;
   logic [IW-1:0]     p_bank;
   logic [ADDR_W-1:0] p_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         base_ifm <= '0;
         base_w1  <= '0;
         base_w2  <= '0;
         cnt_ifm  <= '0;
         cnt_w1   <= '0;
         cnt_w2   <= '0;
         idx      <= '0;
         laddr    <= '0;
         bank_ctr <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_ifm <= base_addr_IFM;
                  base_w1  <= base_addr_Weight_layer_1;
                  base_w2  <= base_addr_Weight_layer_2;
                  cnt_ifm  <= size_IFM >> BYTE_SHIFT;
                  cnt_w1   <= size_Weight_layer_1 >> BYTE_SHIFT;
                  cnt_w2   <= size_Weight_layer_2 >> BYTE_SHIFT;
                  idx      <= '0;
                  laddr    <= '0;
                  bank_ctr <= '0;
                  busy     <= 1'b1;
                  overflow <= 1'b0;
                  state    <= first_load((size_IFM >> BYTE_SHIFT) != '0,
                                         (size_Weight_layer_1 >> BYTE_SHIFT) != '0,
                                         (size_Weight_layer_2 >> BYTE_SHIFT) != '0);
               end
            end
            ST_LOAD_IFM, ST_LOAD_W1, ST_LOAD_W2: begin
               if (!hold) begin
                  if (dst_ovf) overflow <= 1'b1;
                  if (last_issue) begin
                     idx      <= '0;
                     laddr    <= '0;
                     bank_ctr <= '0;
                     case (state)
                        ST_LOAD_IFM: state <= first_load(1'b0, cnt_w1 != '0, cnt_w2 != '0);
                        ST_LOAD_W1:  state <= first_load(1'b0, 1'b0, cnt_w2 != '0);
                        default:     state <= ST_DRAIN;
                     endcase
                  end else begin
                     idx <= idx + ADDR_W'(1);
                     // Interleaved regions: bank rotates, local address steps on wrap
                     if (rgn != RG_IFM) begin
                        if (bank_wrap) begin
                           bank_ctr <= '0;
                           laddr    <= laddr + ADDR_W'(1);
                        end else begin
                           bank_ctr <= bank_ctr + BKW'(1);
                        end
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (!p_pend) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   fused_rd_pipe #(
      .LAT (RD_LATENCY),
      .IW  (IW),
      .AW  (ADDR_W)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (issue),
      .in_ovf    (dst_ovf),
      .in_bank   (dst_bank),
      .in_addr   (dst_addr),
      .out_valid (p_valid),
      .out_ovf   (p_ovf),
      .out_bank  (p_bank),
      .out_addr  (p_addr),
      .pend      (p_pend)
   );

   logic wr_go;
   assign wr_go = p_valid & ~p_ovf;

   always_comb begin
      we_fused      = '0;
      wr_addr_fused = '0;
      wr_data_fused = '0;
      if (wr_go) begin
         we_fused      = NB'(1) << p_bank;
         wr_addr_fused = p_addr << BYTE_SHIFT;
         wr_data_fused = data_in_global;
      end
   end

`ifdef FUSED_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum <= '0;
      end else if (state == ST_IDLE && start) begin
         checksum <= '0;
      end else if (wr_go) begin
         checksum <= checksum ^ data_in_global;
      end
   end
`endif

endmodule
